// File: rtl/mnist_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mnist_ctrl_pkg
// Shared types and constants for the MNIST inference run controller.
//   state_t      - run controller states
//   errCode_t    - 2-bit error code reported on err_code
//   ERR_*        - error code values
//   IMG_WORDS    - default stream beats per 28x28 image (3136 bytes / 4)
//   CLASS_W      - default width of the predicted class
//   CYC_W        - default width of the cycle/timeout counter
//   isBusyState  - true for the states in which a run is in flight
// ---------------------------------------------------------------------------
package mnist_ctrl_pkg;

  localparam int IMG_WORDS      = 784;
  localparam int CLASS_W        = 4;
  localparam int CYC_W          = 24;
  localparam int TIMEOUT_CYCLES = 65536;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LAUNCH      = 3'd1,
    ST_STREAM      = 3'd2,
    ST_WAIT_RESULT = 3'd3,
    ST_DONE        = 3'd4,
    ST_ERROR       = 3'd5
  } state_t;

  typedef logic [1:0] errCode_t;

  localparam errCode_t ERR_NONE    = 2'b00;
  localparam errCode_t ERR_TIMEOUT = 2'b01;
  localparam errCode_t ERR_ABORT   = 2'b10;
  localparam errCode_t ERR_PROTO   = 2'b11;

  // A run is "in flight" from the loader start pulse until a result or error.
  function automatic logic isBusyState(input state_t s);
    return (s == ST_LAUNCH) || (s == ST_STREAM) || (s == ST_WAIT_RESULT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   i_clk    - clock, rising edge
//   i_reset  - synchronous active-high reset, clears the count
//   i_clr    - synchronous clear (takes priority over i_en)
//   i_en     - count enable
//   o_count  - current count, registered
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Clear wins over enable so a new run always starts from zero; once the
  // count reaches all-ones it holds there rather than wrapping to zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/inference_sequencer.sv
// ---------------------------------------------------------------------------
// inference_sequencer
// Run controller for one MNIST inference pass. A start command pulses the
// image loader, the loader's pixel stream is snooped to count one image's
// worth of beats, then the network's class result is latched and the run
// finishes in DONE, or in ERROR on abort, timeout or a protocol violation.
//   s_axi_aclk / s_axi_areset  - clock, synchronous active-high reset
//   cmd_start, cmd_abort       - host run control
//   irq_ack                    - acknowledge DONE/ERROR, return to IDLE
//   ldr_start                  - one-cycle start pulse to the image loader
//   x_tvalid, x_tready         - snooped loader stream handshake
//   nn_result_valid/_class     - network result strobe and predicted class
//   busy, done, error          - run status flags
//   err_code                   - 00 none, 01 timeout, 10 abort, 11 protocol
//   result_class               - latched class, valid while done
//   beat_count, cycle_count    - beats accepted and cycles spent this run
// All outputs are registered.
// ---------------------------------------------------------------------------
module inference_sequencer #(
  parameter int IMG_WORDS      = mnist_ctrl_pkg::IMG_WORDS,
  parameter int CLASS_W        = mnist_ctrl_pkg::CLASS_W,
  parameter int CYC_W          = mnist_ctrl_pkg::CYC_W,
  parameter int TIMEOUT_CYCLES = mnist_ctrl_pkg::TIMEOUT_CYCLES
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_areset,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  input  logic               irq_ack,
  output logic               ldr_start,
  input  logic               x_tvalid,
  input  logic               x_tready,
  input  logic               nn_result_valid,
  input  logic [CLASS_W-1:0] nn_result_class,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [CLASS_W-1:0] result_class,
  output logic [9:0]         beat_count,
  output logic [CYC_W-1:0]   cycle_count
);

  import mnist_ctrl_pkg::*;

  state_t             r_state;
  errCode_t           r_errCode;
  logic               r_ldrStart;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [CLASS_W-1:0] r_resultClass;
  logic [9:0]         r_beatCount;

  state_t             w_nextState;
  errCode_t           w_nextErr;
  logic               w_start;
  logic               w_latchClass;
  logic               w_beat;
  logic               w_busy;
  logic               w_finalBeat;
  logic               w_timeoutHit;
  logic [CYC_W-1:0]   w_cycleCount;

  // Cycle counter runs only while a run is in flight and restarts on launch.
  sat_counter #(
    .W (CYC_W)
  ) u_cycleCounter (
    .i_clk   (s_axi_aclk),
    .i_reset (s_axi_areset),
    .i_clr   (w_start),
    .i_en    (w_busy),
    .o_count (w_cycleCount)
  );

  // Next-state decision. The normal flow is worked out first, then abort and
  // timeout override it in that order, which gives the required precedence
  // abort > timeout > protocol > normal. The timeout fires on the edge where
  // the cycle count would reach TIMEOUT_CYCLES, so the run ends with
  // cycle_count == TIMEOUT_CYCLES.
  always_comb begin
    w_beat       = x_tvalid & x_tready;
    w_busy       = isBusyState(r_state);
    w_finalBeat  = w_beat && (r_beatCount == 10'(IMG_WORDS - 1));
    w_timeoutHit = (w_cycleCount == CYC_W'(TIMEOUT_CYCLES - 1));
    w_nextState  = r_state;
    w_nextErr    = r_errCode;
    w_start      = 1'b0;
    w_latchClass = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (cmd_start) begin
          w_nextState = ST_LAUNCH;
          w_nextErr   = ERR_NONE;
          w_start     = 1'b1;
        end else if (irq_ack && (r_state != ST_IDLE)) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        w_nextState = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_finalBeat) begin
          if (nn_result_valid) begin
            w_nextState  = ST_DONE;
            w_latchClass = 1'b1;
          end else begin
            w_nextState = ST_WAIT_RESULT;
          end
        end else if (nn_result_valid) begin
          w_nextState = ST_ERROR;
          w_nextErr   = ERR_PROTO;
        end
      end
      ST_WAIT_RESULT: begin
        if (w_beat) begin
          w_nextState = ST_ERROR;
          w_nextErr   = ERR_PROTO;
        end else if (nn_result_valid) begin
          w_nextState  = ST_DONE;
          w_latchClass = 1'b1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase

    if (w_busy) begin
      if (cmd_abort) begin
        w_nextState  = ST_ERROR;
        w_nextErr    = ERR_ABORT;
        w_latchClass = 1'b0;
      end else if (w_timeoutHit) begin
        w_nextState  = ST_ERROR;
        w_nextErr    = ERR_TIMEOUT;
        w_latchClass = 1'b0;
      end
    end
  end

  // State and status registers. Status flags are decoded from the next state
  // so they line up with the state register and never depend combinationally
  // on inputs. ldr_start is high exactly while in LAUNCH, which lasts one
  // cycle. Beats are counted only in STREAM; a stray beat in WAIT_RESULT is
  // an error, not part of the image.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state       <= ST_IDLE;
      r_errCode     <= ERR_NONE;
      r_ldrStart    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_resultClass <= '0;
      r_beatCount   <= '0;
    end else begin
      r_state    <= w_nextState;
      r_errCode  <= w_nextErr;
      r_ldrStart <= (w_nextState == ST_LAUNCH);
      r_busy     <= isBusyState(w_nextState);
      r_done     <= (w_nextState == ST_DONE);
      r_error    <= (w_nextState == ST_ERROR);

      if (w_start) begin
        r_resultClass <= '0;
      end else if (w_latchClass) begin
        r_resultClass <= nn_result_class;
      end

      if (w_start) begin
        r_beatCount <= '0;
      end else if ((r_state == ST_STREAM) && w_beat) begin
        r_beatCount <= r_beatCount + 10'd1;
      end
    end
  end

  assign ldr_start    = r_ldrStart;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign err_code     = r_errCode;
  assign result_class = r_resultClass;
  assign beat_count   = r_beatCount;
  assign cycle_count  = w_cycleCount;

endmodule

// File: tb/tb_inference_sequencer.sv
// ---------------------------------------------------------------------------
// tb_inference_sequencer
// Self-checking bench for inference_sequencer. A run-level reference model
// (run active flag, launch flag, beat and cycle tallies, final status) is
// advanced once per clock from the same inputs the DUT sees, and every
// output is compared against it after each edge.
// ---------------------------------------------------------------------------
module tb_inference_sequencer;

  localparam int IMG = 784;
  localparam int CW  = 4;
  localparam int CYW = 24;
  localparam int TMO = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmdStart;
  logic          cmdAbort;
  logic          irqAck;
  logic          xValid;
  logic          xReady;
  logic          resValid;
  logic [CW-1:0] resClass;

  logic           ldrStart;
  logic           busyO;
  logic           doneO;
  logic           errorO;
  logic [1:0]     errCode;
  logic [CW-1:0]  resultClass;
  logic [9:0]     beatCount;
  logic [CYW-1:0] cycleCount;

  int checks = 0;
  int passes = 0;

  // Reference model state
  bit mActive = 0;
  bit mLaunch = 0;
  bit mDone   = 0;
  bit mError  = 0;
  int mBeats  = 0;
  int mCycles = 0;
  int mClass  = 0;
  int mErr    = 0;

  always #5 clk = ~clk;

  inference_sequencer #(
    .IMG_WORDS      (IMG),
    .CLASS_W        (CW),
    .CYC_W          (CYW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .s_axi_aclk      (clk),
    .s_axi_areset    (rst),
    .cmd_start       (cmdStart),
    .cmd_abort       (cmdAbort),
    .irq_ack         (irqAck),
    .ldr_start       (ldrStart),
    .x_tvalid        (xValid),
    .x_tready        (xReady),
    .nn_result_valid (resValid),
    .nn_result_class (resClass),
    .busy            (busyO),
    .done            (doneO),
    .error           (errorO),
    .err_code        (errCode),
    .result_class    (resultClass),
    .beat_count      (beatCount),
    .cycle_count     (cycleCount)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic endWithError(input int code);
    mActive = 0;
    mError  = 1;
    mErr    = code;
  endtask

  // Advance the reference model by one clock using the inputs just sampled.
  task automatic modelStep();
    bit beat;
    bit wasLaunch;
    bit inStream;
    bit finalNow;
    beat = xValid && xReady;
    if (rst) begin
      mActive = 0; mLaunch = 0; mDone = 0; mError = 0;
      mBeats = 0; mCycles = 0; mClass = 0; mErr = 0;
    end else if (!mActive) begin
      if (cmdStart) begin
        mActive = 1; mLaunch = 1; mDone = 0; mError = 0;
        mBeats = 0; mCycles = 0; mClass = 0; mErr = 0;
      end else if (irqAck) begin
        mDone = 0; mError = 0;
      end
    end else begin
      wasLaunch = mLaunch;
      inStream  = !mLaunch && (mBeats < IMG);
      mLaunch   = 0;
      if (mCycles < (2**CYW) - 1) mCycles++;
      if (inStream && beat) mBeats++;
      finalNow = inStream && (mBeats == IMG);
      if (cmdAbort) endWithError(2);
      else if (mCycles == TMO) endWithError(1);
      else if (wasLaunch) begin
      end else if (inStream) begin
        if (resValid) begin
          if (finalNow) begin
            mActive = 0; mDone = 1; mClass = int'(resClass);
          end else begin
            endWithError(3);
          end
        end
      end else begin
        if (beat) endWithError(3);
        else if (resValid) begin
          mActive = 0; mDone = 1; mClass = int'(resClass);
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic applyStimulus(input bit r, input bit s, input bit a, input bit k,
                               input bit v, input bit rd, input bit rv,
                               input logic [CW-1:0] rc);
    rst = r; cmdStart = s; cmdAbort = a; irqAck = k;
    xValid = v; xReady = rd; resValid = rv; resClass = rc;
    @(posedge clk);
    #1;
    modelStep();
    checkOutput("ldr_start", ldrStart, mLaunch);
    checkOutput("busy", busyO, mActive);
    checkOutput("done", doneO, mDone);
    checkOutput("error", errorO, mError);
    checkOutput("err_code", errCode, mErr);
    checkOutput("result_class", resultClass, mClass);
    checkOutput("beat_count", beatCount, mBeats);
    checkOutput("cycle_count", cycleCount, mCycles);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  // Feed beats until the run has accepted 'target' beats or ends early.
  task automatic streamBeats(input int target, input int readyPct,
                             input int abortPerMille, input int startPerMille);
    int guard;
    bit rd;
    bit a;
    bit s;
    guard = 0;
    while (mActive && (mBeats < target) && (guard < 20000)) begin
      rd = ($urandom_range(99) < readyPct);
      a  = ($urandom_range(999) < abortPerMille);
      s  = ($urandom_range(999) < startPerMille);
      applyStimulus(0, s, a, 0, 1, rd, 0, '0);
      guard++;
    end
    if (guard >= 20000) checkOutput("stream_bound", guard, 0);
  endtask

  task automatic waitRunEnd(input int limit);
    int n;
    n = 0;
    while (mActive && (n < limit)) begin
      idleCycles(1);
      n++;
    end
    if (mActive) checkOutput("run_end_bound", n, 0);
  endtask

  initial begin
    $display("[TB] inference_sequencer bench starting");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
    checkOutput("reset_busy", busyO, 0);
    checkOutput("reset_cycles", cycleCount, 0);
    // Abort and ack while idle do nothing
    applyStimulus(0, 0, 1, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, '0);

    // Nominal back-to-back run, result two cycles after the last beat
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    checkOutput("nom_ldr_start", ldrStart, 1);
    streamBeats(IMG, 100, 0, 0);
    idleCycles(2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd7);
    checkOutput("nom_done", doneO, 1);
    checkOutput("nom_class", resultClass, 7);
    checkOutput("nom_beats", beatCount, 784);
    checkOutput("nom_cycles", cycleCount, 788);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, '0);
    checkOutput("nom_ack_done", doneO, 0);
    checkOutput("nom_ack_class_kept", resultClass, 7);

    // Backpressure with stray start requests while busy
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    streamBeats(IMG, 50, 0, 20);
    idleCycles($urandom_range(3));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd3);
    checkOutput("bp_class", resultClass, 3);
    checkOutput("bp_beats", beatCount, 784);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, '0);

    // Timeout: stream stalls at 500 beats
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    streamBeats(500, 100, 0, 0);
    waitRunEnd(TMO + 10);
    checkOutput("tmo_code", errCode, 1);
    checkOutput("tmo_cycles", cycleCount, TMO);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, '0);

    // Abort at beat 100, then acknowledge
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    streamBeats(100, 100, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, '0);
    checkOutput("abort_code", errCode, 2);
    checkOutput("abort_beats", beatCount, 100);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, '0);
    checkOutput("abort_ack_error", errorO, 0);

    // Result before the final beat
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    streamBeats(783, 100, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd2);
    checkOutput("early_res_code", errCode, 3);

    // Start and ack together from ERROR: start wins
    applyStimulus(0, 1, 0, 1, 0, 0, 0, '0);
    checkOutput("start_wins_busy", busyO, 1);
    streamBeats(783, 100, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 4'd9);
    checkOutput("final_res_done", doneO, 1);
    checkOutput("final_res_class", resultClass, 9);
    checkOutput("final_res_beats", beatCount, 784);

    // Extra beat while waiting for the result
    applyStimulus(0, 1, 0, 1, 0, 0, 0, '0);
    streamBeats(IMG, 100, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, '0);
    checkOutput("extra_beat_code", errCode, 3);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, '0);

    // Reset in the middle of streaming, then a clean run
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    streamBeats(400, 100, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, '0);
    checkOutput("midrst_beats", beatCount, 0);
    checkOutput("midrst_busy", busyO, 0);
    idleCycles(2);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    streamBeats(IMG, 100, 0, 0);
    idleCycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd5);
    checkOutput("post_rst_class", resultClass, 5);

    // Randomised runs with occasional aborts and stray starts
    for (int run = 0; run < 4; run++) begin
      applyStimulus(0, 1, 0, $urandom_range(1), 0, 0, 0, '0);
      streamBeats(IMG, 70, 2, 5);
      for (int j = 0; j < 5 && mActive; j++)
        applyStimulus(0, $urandom_range(1), 0, 0, 0, 0, 0, '0);
      if (mActive) applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'($urandom_range(9)));
      applyStimulus(0, 0, 0, 1, 0, 0, 0, '0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
